// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmitter
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte handshake into the UART transmitter
interface uart_tx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] in_data;
  logic                      in_valid;
  logic                      in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte buffer between the handshake and the serialiser
module tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = UART_DATA_BITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - buffered 8N1 UART transmitter with registered serial output
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  uart_tx_if.slave                    in_if,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(UART_DATA_BITS - 1);

  tx_state_e                 state_q, state_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic [BW-1:0]             bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      tx_q, tx_d;

  logic [UART_DATA_BITS-1:0] fifo_rdata;
  logic                      fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic                      bit_end;

  assign in_if.in_ready = !fifo_full;
  assign fifo_push      = in_if.in_valid && !fifo_full;
  assign bit_end        = (timer_q == TIMER_LAST);

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (in_if.in_data),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        timer_d = bit_end ? '0 : timer_q + TW'(1);
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        timer_d = bit_end ? '0 : timer_q + TW'(1);
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == BIT_LAST) state_d = ST_STOP;
          else                       bit_idx_d = bit_idx_q + BW'(1);
        end
      end
      ST_STOP: begin
        timer_d = bit_end ? '0 : timer_q + TW'(1);
        // Chain straight into the next start bit when more bytes are waiting.
        if (bit_end) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The line follows the current state one clock later, keeping tx glitch-free.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_q[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4: byte buffer entries; power of two, 2..16.
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  8  byte to transmit.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_ready  output  1  block can accept a byte this cycle.
REQ-009 tx  output  1  serial line; 8N1 framing, idle high.
REQ-010 busy  output  1  a frame is on the line or the FIFO is non-empty.
REQ-011 fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes buffered.

Function
REQ-012 The block SHALL accept a byte on any rising edge where in_valid and in_ready are both 1.
REQ-013 in_ready SHALL equal (fifo_count != FIFO_DEPTH), driven combinationally from registered state only.
REQ-014 Bytes SHALL be transmitted in acceptance order; none dropped, none duplicated.
REQ-015 FSM states: IDLE, START, DATA, STOP.
REQ-016 IDLE: tx=1; if FIFO non-empty, on the next edge pop the head into the shift register, clear the bit timer, and enter START.
REQ-017 START: tx=0 for exactly CLKS_PER_BIT cycles, then enter DATA with bit index 0.
REQ-018 DATA: tx = shift register bit 0 (LSB first), each bit held exactly CLKS_PER_BIT cycles; shift right after each bit; after bit 7 enter STOP.
REQ-019 STOP: tx=1 for exactly CLKS_PER_BIT cycles; at the end, if FIFO non-empty, pop and enter START directly (no idle gap), else enter IDLE.
REQ-020 One frame SHALL occupy exactly 10*CLKS_PER_BIT cycles.
REQ-021 tx SHALL be a registered output; first start-bit low appears on the edge after the byte is visible to the FSM in IDLE (2 edges after acceptance from empty/idle).
REQ-022 Simultaneous push and pop SHALL both take effect; fifo_count unchanged.
REQ-023 Push while full SHALL NOT occur (in_ready=0); in_valid with in_ready=0 SHALL be ignored with no state change.
REQ-024 in_data is not held by the block beyond the accepting edge; later changes to in_data SHALL NOT affect buffered bytes.
REQ-025 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; count held in a separate counter.
REQ-026 Bit timer width = $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1, then wraps.
REQ-027 busy SHALL be 1 whenever state != IDLE or fifo_count != 0.

Reset
REQ-028 Reset asserted SHALL immediately force: state=IDLE, tx=1, FIFO empty (fifo_count=0), in_ready=1, busy=0, bit timer and bit index 0.
REQ-029 Reset mid-frame SHALL abort the frame and discard all buffered bytes; no partial frame resumes after release.
REQ-030 First acceptance is permitted on the first rising edge after reset deasserts.

Structure
REQ-031 Package uart_pkg SHALL hold the tx state enum (2 bits) and constant UART_DATA_BITS=8.
REQ-032 Byte buffer SHALL be sub-module tx_fifo (push, pop, data in/out, count, full, empty), parameterised by FIFO_DEPTH.
REQ-033 FSM, bit timer and shift register reside in uart_tx.

Verification
REQ-034 Reset then push 0xA5 with CLKS_PER_BIT=16 -> tx low at edge+2 for 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high 16 cycles; busy falls after 160 cycles.
REQ-035 Push 0x00, 0xFF, 0x55, 0x3C back-to-back -> in_ready stays 1, fifo_count peaks at 3 or 4, four contiguous frames of 160 cycles each, no idle gap.
REQ-036 Push 6 bytes with FIFO_DEPTH=4 while in_valid held -> in_ready drops to 0 at fifo_count=4; held byte accepted when a pop frees space; all 6 bytes emitted in order.
REQ-037 Push on the same edge as a STOP-end pop with fifo_count=1 -> fifo_count stays 1, next frame carries the older byte.
REQ-038 Assert reset mid-DATA (bit 3) -> tx=1 asynchronously, fifo_count=0, no frame follows release until new push.
REQ-039 CLKS_PER_BIT=2 corner: push 0x81 -> frame of exactly 20 cycles, bits correct; loopback into the team's uart_rx at matching oversample rate recovers 0x81.
